servo_pwm_mmio: RTL
===================

// Module: servo_pwm_mmio
// PURPOSE
//   Memory-mapped responder on the processor data-memory bus (wren/address_dmem/data/q_dmem) driving six servo PWM outputs.
//   The CPU stores a position byte and enable bits; the block emits 50 Hz servo pulses from 1000 to 2000 us.
//   It sits in the wrapper beside the RAM; the wrapper muxes q_dmem between RAM and this block using hit.
// PARAMETERS
//   NUM_SERVOS  6               number of servo channels (1..8)
//   CLK_HZ      100_000_000     clock frequency; CLK_HZ/1_000_000 must be an integer >= 2
//   PERIOD_US   20000           PWM frame length in us
//   BASE_ADDR   12'hF00         block base; decode is address_dmem[11:4] == BASE_ADDR[11:4]
// PORTS
//   clock        in   1   system clock; all logic is on the rising edge
//   reset        in   1   asynchronous, active-high reset
//   wren         in   1   processor store strobe
//   address_dmem in   32  processor word address; only bits [11:0] are used
//   data         in   32  store data
//   rdata        out  32  registered read data; 0 when not selected
//   hit          out  1   registered: the previous cycle's address decoded to this block
//   servo        out  NUM_SERVOS  PWM outputs; servo[0] drives servo1, etc.
// BEHAVIOUR
//   Register map (offset = address_dmem[3:0]):
//     0..5  POSn     R/W  8-bit position; a write of a value > 250 saturates to 250; reads return the stored value
//     6     ENABLE   R/W  [NUM_SERVOS-1:0]; one bit per channel
//     7     FRAME    R    16-bit count of completed frames; wraps 0xFFFF -> 0; writes are ignored
//     8..15 --       reads return 0; writes are ignored
//   Offsets >= NUM_SERVOS within 0..5 behave as unused offsets.
//   Write: sel && wren updates the shadow register on that clock edge. Only data[7:0] / data[NUM_SERVOS-1:0] are used.
//   Read: sel && !wren -> rdata <= zero-extended register next cycle (1-cycle latency, same as RAM). Otherwise rdata <= 0.
//   hit <= sel on every cycle.
//   Timebase:
//     - Prescaler counts 0..CLK_HZ/1e6-1 and emits a one-clock tick_us at terminal count.
//     - us_cnt counts 0..PERIOD_US-1 on tick_us and wraps to 0.
//   Frame boundary: tick_us && us_cnt == PERIOD_US-1.
//     - active_pos[n] <= shadow POSn.
//     - active_en <= ENABLE.
//     - FRAME increments.
//   Pulse width: pw_us[n] = 1000 + 4*active_pos[n]. Range 1000..2000 us; 11-bit arithmetic with no overflow.
//   Output: servo[n] <= active_en[n] && (us_cnt < pw_us[n]). Registered; one clock behind us_cnt.
//   Pulses therefore begin at us_cnt == 0 and never change width mid-frame (glitch-free double buffering).
//   Simultaneous CPU write and frame boundary: active_* samples the pre-write shadow value; the new value applies from the following frame.
//   Clearing an ENABLE bit mid-frame has no effect until the next boundary. The current pulse completes.
//   Reset (any time, including mid-pulse):
//     - servo = 0, rdata = 0, hit = 0.
//     - Prescaler, us_cnt and FRAME = 0.
//     - Shadow and active POSn = 125 (1500 us centre).
//     - ENABLE and active_en = 0.
//   After reset deassertion the first frame starts at us_cnt = 0. Outputs stay low until ENABLE is written and a boundary passes.
// STRUCTURE
//   Shared include servo_defs.vh holds:
//     - Register offsets OFF_POS0..OFF_POS5, OFF_ENABLE, OFF_FRAME.
//     - Constants POS_MAX = 250, POS_RESET = 125, PW_MIN_US = 1000, PW_STEP_US = 4.
//   Sub-module servo_pwm_channel, one instance per servo:
//     - Inputs: clock, reset, frame_load, shadow_pos, shadow_en, us_cnt.
//     - Holds active_pos/active_en and drives the registered compare output.
//   The top level holds bus decode, shadow registers, readback mux, prescaler, us_cnt and FRAME.
// TESTING (sim with CLK_HZ=2_000_000 and PERIOD_US=20000, i.e. 2 clocks/us and a 40000-clock frame)
//   1. Write POS0=0, ENABLE=1; wait for a boundary -> servo[0] high for exactly 2000 clocks per 40000-clock frame; servo[5:1] = 0.
//   2. Write POS2=255, then read offset 2 -> rdata = 250 one cycle after the read and hit=1; pulse is 4000 clocks.
//   3. Write POS0=250 at us_cnt=500 of a running frame -> current pulse stays 2000 clocks; next frame's pulse is 4000 clocks.
//   4. Write at a boundary-coincident cycle -> that frame uses the old value and the next frame uses the new one.
//   5. Assert reset mid-pulse -> servo = 0 in the same cycle; POS0 reads 125; ENABLE reads 0; FRAME reads 0.
//   6. Run 3 frames and read offset 7 -> 3.
//   7. Write to address 12'hE06 -> hit=0 and ENABLE unchanged; write FRAME -> ignored.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// Shared register map, position limits and pulse-width helpers for the servo PWM block.
package servo_pwm_pkg;

    localparam logic [3:0] OFF_POS0   = 4'd0;
    localparam logic [3:0] OFF_POS1   = 4'd1;
    localparam logic [3:0] OFF_POS2   = 4'd2;
    localparam logic [3:0] OFF_POS3   = 4'd3;
    localparam logic [3:0] OFF_POS4   = 4'd4;
    localparam logic [3:0] OFF_POS5   = 4'd5;
    localparam logic [3:0] OFF_ENABLE = 4'd6;
    localparam logic [3:0] OFF_FRAME  = 4'd7;

    localparam int NUM_POS_REGS = 6;

    localparam logic [7:0]  POS_MAX    = 8'd250;
    localparam logic [7:0]  POS_RESET  = 8'd125;
    localparam logic [10:0] PW_MIN_US  = 11'd1000;
    localparam logic [10:0] PW_STEP_US = 11'd4;

    function automatic logic [7:0] sat_pos(input logic [7:0] v);
        logic [7:0] r;
        if (v > POS_MAX) begin
            r = POS_MAX;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // 1000 + 4*250 = 2000 still fits in 11 bits
    function automatic logic [10:0] pos_to_pw(input logic [7:0] p);
        return PW_MIN_US + (PW_STEP_US * {3'b000, p});
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: double-buffered position/enable latched at the frame boundary,
// plus the registered width compare against the shared microsecond counter.
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int UW = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_load,
    input  logic [7:0]    shadow_pos,
    input  logic          shadow_en,
    input  logic [UW-1:0] us_cnt,
    output logic          servo
);

    localparam int CW = (UW > 11) ? UW : 11;

    logic [7:0]  active_pos_r;
    logic        active_en_r;
    logic [10:0] pw_s;
    logic        pulse_s;

    // Active copy only changes at a frame boundary so a pulse never changes width mid-frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_pos_r <= POS_RESET;
            active_en_r  <= 1'b0;
        end else if (frame_load) begin
            active_pos_r <= shadow_pos;
            active_en_r  <= shadow_en;
        end else begin
            active_pos_r <= active_pos_r;
            active_en_r  <= active_en_r;
        end
    end

    // Width compare for the current microsecond
    always_comb begin
        pw_s    = pos_to_pw(active_pos_r);
        pulse_s = active_en_r && (CW'(us_cnt) < CW'(pw_s));
    end

    // Registered output, one clock behind us_cnt
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            servo <= 1'b0;
        end else begin
            servo <= pulse_s;
        end
    end

endmodule

// File: rtl/servo_pwm_mmio.sv
// Memory-mapped servo PWM block: bus decode, shadow registers, readback, timebase
// and frame counter, driving one servo_pwm_channel per output.
module servo_pwm_mmio
    import servo_pwm_pkg::*;
#(
    parameter int          NUM_SERVOS = 6,
    parameter int          CLK_HZ     = 100_000_000,
    parameter int          PERIOD_US  = 20000,
    parameter logic [11:0] BASE_ADDR  = 12'hF00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wren,
    input  logic [31:0]           address_dmem,
    input  logic [31:0]           data,
    output logic [31:0]           rdata,
    output logic                  hit,
    output logic [NUM_SERVOS-1:0] servo
);

    localparam int DIV  = CLK_HZ / 1_000_000;
    localparam int PSW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int UW   = $clog2(PERIOD_US);
    localparam int NPOS = (NUM_SERVOS < NUM_POS_REGS) ? NUM_SERVOS : NUM_POS_REGS;

    localparam logic [PSW-1:0] PRE_LAST = PSW'(DIV - 1);
    localparam logic [UW-1:0]  US_LAST  = UW'(PERIOD_US - 1);

    logic                  sel_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [3:0]            off_s;
    logic                  tick_s;
    logic                  frame_s;
    logic [PSW-1:0]        presc_r;
    logic [UW-1:0]         us_cnt_r;
    logic [15:0]           frame_cnt_r;
    logic [7:0]            shadow_pos_r [NUM_SERVOS];
    logic [NUM_SERVOS-1:0] shadow_en_r;
    logic [7:0]            pos_rd_s;
    logic [31:0]           rd_mux_s;
    logic                  unused_s;

    assign unused_s = ^{address_dmem[31:12], data[31:8]};

    // Address decode and timebase strobes
    always_comb begin
        off_s   = address_dmem[3:0];
        sel_s   = (address_dmem[11:4] == BASE_ADDR[11:4]);
        wr_s    = sel_s && wren;
        rd_s    = sel_s && !wren;
        tick_s  = (presc_r == PRE_LAST);
        frame_s = tick_s && (us_cnt_r == US_LAST);
    end

    // Prescaler, microsecond counter and completed-frame counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_r     <= {PSW{1'b0}};
            us_cnt_r    <= {UW{1'b0}};
            frame_cnt_r <= 16'd0;
        end else begin
            if (tick_s) begin
                presc_r <= {PSW{1'b0}};
                if (us_cnt_r == US_LAST) begin
                    us_cnt_r <= {UW{1'b0}};
                end else begin
                    us_cnt_r <= us_cnt_r + UW'(1);
                end
            end else begin
                presc_r  <= presc_r + PSW'(1);
                us_cnt_r <= us_cnt_r;
            end
            if (frame_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // CPU-visible shadow registers; channels without a POS offset keep the centre value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                shadow_pos_r[i] <= POS_RESET;
            end
            shadow_en_r <= {NUM_SERVOS{1'b0}};
        end else begin
            for (int i = 0; i < NPOS; i++) begin
                if (wr_s && (off_s == 4'(i))) begin
                    shadow_pos_r[i] <= sat_pos(data[7:0]);
                end else begin
                    shadow_pos_r[i] <= shadow_pos_r[i];
                end
            end
            if (wr_s && (off_s == OFF_ENABLE)) begin
                shadow_en_r <= data[NUM_SERVOS-1:0];
            end else begin
                shadow_en_r <= shadow_en_r;
            end
        end
    end

    // Readback mux; POS offsets without a channel read as zero
    always_comb begin
        pos_rd_s = 8'd0;
        for (int i = 0; i < NPOS; i++) begin
            pos_rd_s = pos_rd_s | ((off_s == 4'(i)) ? shadow_pos_r[i] : 8'd0);
        end
        case (off_s)
            OFF_POS0, OFF_POS1, OFF_POS2,
            OFF_POS3, OFF_POS4, OFF_POS5: rd_mux_s = {24'd0, pos_rd_s};
            OFF_ENABLE:                   rd_mux_s = {{(32 - NUM_SERVOS){1'b0}}, shadow_en_r};
            OFF_FRAME:                    rd_mux_s = {16'd0, frame_cnt_r};
            default:                      rd_mux_s = 32'd0;
        endcase
    end

    // Registered bus response, same one-cycle latency as the RAM beside it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= 32'd0;
            hit   <= 1'b0;
        end else begin
            hit <= sel_s;
            if (rd_s) begin
                rdata <= rd_mux_s;
            end else begin
                rdata <= 32'd0;
            end
        end
    end

    for (genvar n = 0; n < NUM_SERVOS; n++) begin : g_ch
        servo_pwm_channel #(
            .UW (UW)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .frame_load (frame_s),
            .shadow_pos (shadow_pos_r[n]),
            .shadow_en  (shadow_en_r[n]),
            .us_cnt     (us_cnt_r),
            .servo      (servo[n])
        );
    end

endmodule
